// File: rtl/bank_cmd_timing_arbiter.sv
// Round-robin arbiter for the shared DFI command slot: enforces tRRD/tFAW/tCCD,
// registers the winner into a one-entry output stage, and yields the bus to refresh.
module bank_cmd_timing_arbiter #(
  parameter int NBANK = 8,
  parameter int IDXW  = 3,
  parameter int CFGW  = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [NBANK-1:0] req_valid,
  input  logic [NBANK-1:0] req_is_act,
  input  logic [NBANK-1:0] req_is_cas,
  output logic [NBANK-1:0] req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_is_act,
  output logic             out_is_cas,
  input  logic             refresh_req,
  output logic             refresh_gnt,
  input  logic [CFGW-1:0]  tRRD_cfg,
  input  logic [CFGW-1:0]  tFAW_cfg,
  input  logic [CFGW-1:0]  tCCD_cfg
);

  typedef enum logic [1:0] {ARB, DRAIN, REF} state_t;

  state_t           state;
  logic [IDXW-1:0]  rr_ptr;
  logic [CFGW-1:0]  trrd_cnt;
  logic [CFGW-1:0]  tccd_cnt;
  logic [CFGW-1:0]  faw_cnt [4];
  logic [2:0]       faw_active;
  logic [1:0]       faw_free_slot;
  logic             act_ok;
  logic             cas_ok;
  logic             accept;
  logic             grant;
  logic             grant_act;
  logic             grant_cas;
  logic             win_found;
  logic [IDXW-1:0]  win_idx;
  logic [NBANK-1:0] elig;

  // A config of 0 or 1 both mean "no spacing", i.e. a reload of 0.
  function automatic logic [CFGW-1:0] reload_val(input logic [CFGW-1:0] cfg);
    return (cfg == '0) ? '0 : cfg - 1'b1;
  endfunction

  function automatic logic [CFGW-1:0] dec_sat(input logic [CFGW-1:0] cnt);
    return (cnt == '0) ? '0 : cnt - 1'b1;
  endfunction

  // Busy FAW slots and the lowest-numbered free one.
  always_comb begin
    faw_active    = '0;
    faw_free_slot = '0;
    for (int s = 3; s >= 0; s--) begin
      if (faw_cnt[s] != '0) faw_active = faw_active + 3'd1;
      else                  faw_free_slot = 2'(s);
    end
  end

  assign act_ok = (trrd_cnt == '0) && (faw_active < 3'd4);
  assign cas_ok = (tccd_cnt == '0);
  assign elig   = req_valid & (~req_is_act | {NBANK{act_ok}})
                            & (~req_is_cas | {NBANK{cas_ok}});

  // Search starts just past the last winner and wraps; rr_ptr itself is tried last.
  always_comb begin
    logic [IDXW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NBANK; k++) begin
      cand = rr_ptr + IDXW'(k);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign accept    = (state == ARB) && !refresh_req && (!out_valid || out_ready) && !sys_rst;
  assign grant     = accept && win_found;
  assign grant_act = grant && req_is_act[win_idx];
  assign grant_cas = grant && req_is_cas[win_idx];
  assign req_ready = grant ? (NBANK'(1) << win_idx) : '0;

  // Output stage, timing counters and refresh handshake.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      out_valid   <= 1'b0;
      out_idx     <= '0;
      out_is_act  <= 1'b0;
      out_is_cas  <= 1'b0;
      rr_ptr      <= IDXW'(NBANK - 1);
      trrd_cnt    <= '0;
      tccd_cnt    <= '0;
      for (int s = 0; s < 4; s++) faw_cnt[s] <= '0;
      state       <= ARB;
      refresh_gnt <= 1'b0;
    end else begin
      if (grant) begin
        out_valid  <= 1'b1;
        out_idx    <= win_idx;
        out_is_act <= req_is_act[win_idx];
        out_is_cas <= req_is_cas[win_idx];
        rr_ptr     <= win_idx;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end

      trrd_cnt <= grant_act ? reload_val(tRRD_cfg) : dec_sat(trrd_cnt);
      tccd_cnt <= grant_cas ? reload_val(tCCD_cfg) : dec_sat(tccd_cnt);
      for (int s = 0; s < 4; s++) begin
        if (grant_act && (2'(s) == faw_free_slot)) faw_cnt[s] <= reload_val(tFAW_cfg);
        else                                       faw_cnt[s] <= dec_sat(faw_cnt[s]);
      end

      case (state)
        ARB: begin
          if (refresh_req) state <= DRAIN;
        end
        DRAIN: begin
          if (!refresh_req) begin
            state <= ARB;
          end else if (!out_valid || out_ready) begin
            state       <= REF;
            refresh_gnt <= 1'b1;
          end
        end
        REF: begin
          if (!refresh_req) begin
            state       <= ARB;
            refresh_gnt <= 1'b0;
          end
        end
        default: begin
          state       <= ARB;
          refresh_gnt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bank_cmd_timing_arbiter.sv
// Directed bench for bank_cmd_timing_arbiter: a per-cycle vector table followed by
// hand-written ACT-window, reset-during-burst and zero-config sequences.
module tb_bank_cmd_timing_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_valid, req_is_act, req_is_cas, req_ready;
  logic       out_valid, out_ready, out_is_act, out_is_cas;
  logic [2:0] out_idx;
  logic       refresh_req, refresh_gnt;
  logic [7:0] trrd, tfaw, tccd;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic [7:0] v;
    logic [7:0] cas;
    logic       ordy;
    logic       rref;
    logic [7:0] e_rdy;
    logic       e_ov;
    logic [2:0] e_idx;
    logic       e_ic;
    logic       e_gnt;
  } vec_t;

  vec_t tbl[$];

  bank_cmd_timing_arbiter #(.NBANK(8), .IDXW(3), .CFGW(8)) dut (
    .sys_clk(clk), .sys_rst(rst),
    .req_valid(req_valid), .req_is_act(req_is_act), .req_is_cas(req_is_cas),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_is_act(out_is_act), .out_is_cas(out_is_cas),
    .refresh_req(refresh_req), .refresh_gnt(refresh_gnt),
    .tRRD_cfg(trrd), .tFAW_cfg(tfaw), .tCCD_cfg(tccd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [7:0] v, input logic [7:0] cas,
                     input logic ordy, input logic rref, input logic [7:0] rdy,
                     input logic ov, input logic [2:0] idx, input logic ic, input logic gnt);
    vec_t t;
    t.rst = r; t.v = v; t.cas = cas; t.ordy = ordy; t.rref = rref;
    t.e_rdy = rdy; t.e_ov = ov; t.e_idx = idx; t.e_ic = ic; t.e_gnt = gnt;
    tbl.push_back(t);
  endtask

  initial begin
    int exp_bank;
    logic [7:0] cfg0_exp [6];

    // rst  valid  cas  ordy rref | rdy  ov idx ic gnt
    add(1, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0);  // reset state
    add(0, 8'h29, 8'h00, 1, 0, 8'h01, 0, 0, 0, 0);  // round robin 0,3,5
    add(0, 8'h29, 8'h00, 1, 0, 8'h08, 1, 0, 0, 0);
    add(0, 8'h29, 8'h00, 1, 0, 8'h20, 1, 3, 0, 0);
    add(0, 8'h29, 8'h00, 1, 0, 8'h01, 1, 5, 0, 0);
    add(0, 8'h29, 8'h00, 1, 0, 8'h08, 1, 0, 0, 0);
    add(0, 8'h29, 8'h00, 1, 0, 8'h20, 1, 3, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 8'h29, 8'h00, 0, 0, 8'h00, 1, 5, 0, 0);  // backpressure holds stage
    add(0, 8'h29, 8'h00, 1, 0, 8'h01, 1, 5, 0, 0);
    add(0, 8'h00, 8'h00, 1, 0, 8'h00, 1, 0, 0, 0);
    add(0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h46, 8'h06, 1, 0, 8'h02, 0, 0, 0, 0);  // CAS spacing, bank 6 fills
    add(0, 8'h44, 8'h04, 1, 0, 8'h40, 1, 1, 1, 0);
    add(0, 8'h44, 8'h04, 1, 0, 8'h04, 1, 6, 0, 0);
    add(0, 8'h00, 8'h00, 1, 0, 8'h00, 1, 2, 1, 0);
    add(0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 2, 1, 0);
    add(0, 8'h08, 8'h00, 0, 0, 8'h08, 0, 2, 1, 0);  // refresh while stalled
    add(0, 8'h10, 8'h00, 0, 1, 8'h00, 1, 3, 0, 0);
    add(0, 8'h10, 8'h00, 0, 1, 8'h00, 1, 3, 0, 0);
    add(0, 8'h10, 8'h00, 0, 1, 8'h00, 1, 3, 0, 0);
    add(0, 8'h10, 8'h00, 1, 1, 8'h00, 1, 3, 0, 0);
    add(0, 8'h10, 8'h00, 1, 1, 8'h00, 0, 3, 0, 1);
    add(0, 8'h10, 8'h00, 1, 1, 8'h00, 0, 3, 0, 1);
    add(0, 8'h10, 8'h00, 1, 0, 8'h00, 0, 3, 0, 1);
    add(0, 8'h10, 8'h00, 1, 0, 8'h10, 0, 3, 0, 0);
    add(0, 8'h00, 8'h00, 1, 0, 8'h00, 1, 4, 0, 0);
    add(0, 8'h01, 8'h00, 1, 0, 8'h01, 0, 4, 0, 0);
    add(0, 8'h00, 8'h00, 0, 1, 8'h00, 1, 0, 0, 0);  // refresh dropped in DRAIN
    add(0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0);
    add(0, 8'h02, 8'h00, 1, 0, 8'h02, 1, 0, 0, 0);
    add(0, 8'h00, 8'h00, 1, 0, 8'h00, 1, 1, 0, 0);

    rst = 1'b1; req_valid = '0; req_is_act = '0; req_is_cas = '0;
    out_ready = 1'b1; refresh_req = 1'b0;
    trrd = 8'd0; tfaw = 8'd0; tccd = 8'd2;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      #1;
      rst = tbl[i].rst; req_valid = tbl[i].v; req_is_cas = tbl[i].cas; req_is_act = '0;
      out_ready = tbl[i].ordy; refresh_req = tbl[i].rref;
      @(negedge clk);
      chk($sformatf("v%0d req_ready", i),   32'(req_ready),   32'(tbl[i].e_rdy));
      chk($sformatf("v%0d out_valid", i),   32'(out_valid),   32'(tbl[i].e_ov));
      chk($sformatf("v%0d out_idx", i),     32'(out_idx),     32'(tbl[i].e_idx));
      chk($sformatf("v%0d out_is_cas", i),  32'(out_is_cas),  32'(tbl[i].e_ic));
      chk($sformatf("v%0d refresh_gnt", i), 32'(refresh_gnt), 32'(tbl[i].e_gnt));
      @(posedge clk);
    end

    // All banks want ACT: tRRD=4, tFAW=20 -> grants at 0,4,8,12,20,24,28.
    exp_bank = 2;
    for (int c = 0; c < 30; c++) begin
      logic [7:0] e;
      #1;
      req_valid = 8'hFF; req_is_act = 8'hFF; req_is_cas = '0; out_ready = 1'b1;
      trrd = 8'd4; tfaw = 8'd20; tccd = 8'd0;
      @(negedge clk);
      e = 8'h00;
      if (c inside {0, 4, 8, 12, 20, 24, 28}) begin
        e = 8'h01 << exp_bank;
        exp_bank = (exp_bank + 1) % 8;
      end
      chk($sformatf("act c%0d req_ready", c), 32'(req_ready), 32'(e));
      if (c == 1) chk("act c1 out_is_act", 32'(out_is_act), 32'd1);
      @(posedge clk);
    end

    // Reset mid-burst while tRRD is still running.
    #1; rst = 1'b1;
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    chk("postrst req_ready",   32'(req_ready),   32'h01);
    chk("postrst out_valid",   32'(out_valid),   32'd0);
    chk("postrst out_idx",     32'(out_idx),     32'd0);
    chk("postrst out_is_act",  32'(out_is_act),  32'd0);
    chk("postrst refresh_gnt", 32'(refresh_gnt), 32'd0);
    @(posedge clk);

    // Zeroed config takes effect only once the running tRRD (3) expires.
    cfg0_exp = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h04, 8'h08};
    for (int c = 0; c < 6; c++) begin
      #1; trrd = 8'd0; tfaw = 8'd0;
      @(negedge clk);
      chk($sformatf("cfg0 c%0d req_ready", c), 32'(req_ready), 32'(cfg0_exp[c]));
      @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
